// File: rtl/bn_frame_collector.sv
// Collects a channel-tagged sample stream into one packed per-channel frame and
// holds the completed frame until the downstream stage accepts it.
module bn_frame_collector #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 48,
    localparam int unsigned CW      = $clog2(CHANNELS),
    localparam int unsigned NW      = $clog2(CHANNELS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH-1:0]          y_in,
    input  logic [CW-1:0]             channel_in,
    input  logic                      valid_in,
    output logic [CHANNELS*WIDTH-1:0] frame_out,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [NW-1:0]             fill_count,
    output logic                      dup_err,
    output logic                      range_err,
    output logic                      drop_err
);

    localparam int unsigned CW1 = CW + 1;

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e              state_q;
    logic [WIDTH-1:0]    buf_q [CHANNELS];
    logic [CHANNELS-1:0] seen_q;

    logic acc;
    logic in_range;
    logic slot_seen;

    assign acc       = en & valid_in;
    // Widened by one bit so the compare stays meaningful when CHANNELS is a power of two.
    assign in_range  = {1'b0, channel_in} < CW1'(CHANNELS);
    assign slot_seen = seen_q[channel_in];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_pack
        assign frame_out[c*WIDTH +: WIDTH] = buf_q[c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StCollect;
            for (int c = 0; c < CHANNELS; c++) begin
                buf_q[c] <= '0;
            end
            seen_q      <= '0;
            fill_count  <= '0;
            frame_valid <= 1'b0;
            dup_err     <= 1'b0;
            range_err   <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            dup_err   <= 1'b0;
            range_err <= acc & ~in_range;
            drop_err  <= 1'b0;
            unique case (state_q)
                StCollect: begin
                    if (acc && in_range) begin
                        buf_q[channel_in]  <= y_in;
                        seen_q[channel_in] <= 1'b1;
                        if (slot_seen) begin
                            dup_err <= 1'b1;
                        end else begin
                            fill_count <= fill_count + NW'(1);
                            if (fill_count == NW'(CHANNELS - 1)) begin
                                state_q     <= StHold;
                                frame_valid <= 1'b1;
                            end
                        end
                    end
                end
                StHold: begin
                    // Samples are dropped even on the handshake cycle itself.
                    drop_err <= acc & in_range;
                    if (frame_ready) begin
                        seen_q      <= '0;
                        fill_count  <= '0;
                        frame_valid <= 1'b0;
                        state_q     <= StCollect;
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

endmodule

// File: tb/tb_bn_frame_collector.sv
// Randomized and directed bench for bn_frame_collector against a set-based frame model.
module tb_bn_frame_collector;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned CHANNELS = 48;
    localparam int unsigned CW       = $clog2(CHANNELS);
    localparam int unsigned NW       = $clog2(CHANNELS + 1);
    localparam int unsigned FW       = CHANNELS * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] y_in;
    logic [CW-1:0]    channel_in;
    logic             valid_in;
    logic [FW-1:0]    frame_out;
    logic             frame_valid;
    logic             frame_ready;
    logic [NW-1:0]    fill_count;
    logic             dup_err;
    logic             range_err;
    logic             drop_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stored values, set of channels written, and whether a frame is held.
    logic [WIDTH-1:0] m_buf [CHANNELS];
    bit               m_seen [CHANNELS];
    bit               m_hold;
    bit               m_dup, m_rng, m_drop;

    bn_frame_collector #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .y_in        (y_in),
        .channel_in  (channel_in),
        .valid_in    (valid_in),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .fill_count  (fill_count),
        .dup_err     (dup_err),
        .range_err   (range_err),
        .drop_err    (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int distinct();
        int n = 0;
        for (int c = 0; c < CHANNELS; c++) n += int'(m_seen[c]);
        return n;
    endfunction

    function automatic logic [FW-1:0] model_frame();
        logic [FW-1:0] f;
        for (int c = 0; c < CHANNELS; c++) f[c*WIDTH +: WIDTH] = m_buf[c];
        return f;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_buf[c]  = '0;
            m_seen[c] = 1'b0;
        end
        m_hold = 1'b0;
        m_dup  = 1'b0;
        m_rng  = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_edge(input bit a, input int ch, input logic [WIDTH-1:0] y, input bit rdy);
        bit was_hold = m_hold;
        m_dup  = 1'b0;
        m_rng  = 1'b0;
        m_drop = 1'b0;
        if (a) begin
            if (ch >= CHANNELS) m_rng = 1'b1;
            else if (was_hold) m_drop = 1'b1;
            else begin
                m_dup      = m_seen[ch];
                m_seen[ch] = 1'b1;
                m_buf[ch]  = y;
                if (distinct() == CHANNELS) m_hold = 1'b1;
            end
        end
        if (was_hold && rdy) begin
            for (int c = 0; c < CHANNELS; c++) m_seen[c] = 1'b0;
            m_hold = 1'b0;
        end
    endtask

    task automatic compare();
        check("frame_valid", FW'(frame_valid), FW'(m_hold));
        check("fill_count", FW'(fill_count), FW'(distinct()));
        check("frame_out", frame_out, model_frame());
        check("dup_err", FW'(dup_err), FW'(m_dup));
        check("range_err", FW'(range_err), FW'(m_rng));
        check("drop_err", FW'(drop_err), FW'(m_drop));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, compare just after it.
    task automatic step(input bit e, input bit v, input int ch, input int y, input bit rdy);
        en          = e;
        valid_in    = v;
        channel_in  = CW'(ch);
        y_in        = WIDTH'(y);
        frame_ready = rdy;
        @(posedge clk);
        model_edge(e & v, ch, WIDTH'(y), rdy);
        #1;
        compare();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 0, 0, rdy);
    endtask

    // Called at posedge+1; reset lands mid-cycle and must act before the next edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        #1 rst = 1'b0;
        compare();
    endtask

    task automatic fill_shuffled(input bit rdy);
        int perm [CHANNELS];
        for (int c = 0; c < CHANNELS; c++) perm[c] = c;
        for (int c = CHANNELS - 1; c > 0; c--) begin
            int j = int'($urandom_range(c, 0));
            int t = perm[c];
            perm[c] = perm[j];
            perm[j] = t;
        end
        for (int c = 0; c < CHANNELS; c++) step(1'b1, 1'b1, perm[c], int'($urandom()), rdy);
    endtask

    initial begin
        logic [FW-1:0] snap;
        rst = 1'b1;
        en = 1'b0;
        valid_in = 1'b0;
        channel_in = '0;
        y_in = '0;
        frame_ready = 1'b0;
        model_reset();
        #3 compare();
        @(posedge clk);
        #1 rst = 1'b0;

        // Ordered fill with ready tied high.
        for (int c = 0; c < CHANNELS; c++) step(1'b1, 1'b1, c, c * 3 - 70, 1'b1);
        check("ord_slot47", FW'(frame_out[47*16 +: 16]), FW'(16'd71));
        check("ord_slot0", FW'(frame_out[0 +: 16]), FW'(16'hFFBA));
        check("ord_full", FW'(fill_count), FW'(48));
        idle(1'b1);
        check("ord_accepted", FW'(frame_valid), FW'(0));

        // Reverse order with idle gaps and en toggling.
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            int gaps = int'($urandom_range(3, 0));
            for (int g = 0; g < gaps; g++) step(1'($urandom()), 1'b0, c, 16'h5555, 1'b0);
            step(1'b0, 1'b1, (c + 1) % CHANNELS, 16'hAAAA, 1'b0);
            step(1'b1, 1'b1, c, c * 3 - 70, 1'b0);
        end
        check("rev_slot47", FW'(frame_out[47*16 +: 16]), FW'(16'd71));
        check("rev_slot0", FW'(frame_out[0 +: 16]), FW'(16'hFFBA));
        idle(1'b1);

        // Duplicate channel 5: last write wins.
        step(1'b1, 1'b1, 5, 16'h0100, 1'b0);
        step(1'b1, 1'b1, 5, 16'h7FFF, 1'b0);
        for (int c = 0; c < CHANNELS; c++)
            if (c != 5) step(1'b1, 1'b1, c, int'($urandom()), 1'b0);
        check("dup_slot5", FW'(frame_out[5*16 +: 16]), FW'(16'h7FFF));
        idle(1'b1);

        // Hold and drop, including a sample on the handshake cycle.
        fill_shuffled(1'b0);
        snap = model_frame();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 3, 16'h1234, 1'b0);
        step(1'b1, 1'b1, 3, 16'h1234, 1'b1);
        check("hold_frozen", frame_out, snap);
        idle(1'b0);
        check("hold_restart", FW'(fill_count), FW'(0));

        // Out-of-range channels mid-frame.
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1, c, int'($urandom()), 1'b0);
        for (int c = CHANNELS; c < 64; c++) step(1'b1, 1'b1, c, int'($urandom()), 1'b0);
        check("rng_fill", FW'(fill_count), FW'(4));

        // Async reset after 20 channels, then during hold.
        for (int c = 4; c < 20; c++) step(1'b1, 1'b1, c, int'($urandom()), 1'b0);
        async_reset();
        fill_shuffled(1'b0);
        async_reset();
        fill_shuffled(1'b0);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int ch = ($urandom_range(15, 0) == 0) ? int'($urandom_range(63, 48))
                                                  : int'($urandom_range(CHANNELS - 1, 0));
            step(1'($urandom_range(7, 0) != 0), 1'($urandom_range(7, 0) != 0), ch,
                 int'($urandom()), 1'($urandom_range(3, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
